// File: rtl/detect_event_logger.sv
// ---------------------------------------------------------------------------
// detect_event_logger
//
// Timestamps each detection pulse from an upstream sequence detector and
// queues the timestamp in a small FIFO for a downstream consumer. Detections
// that arrive while the FIFO is full are counted as drops and latch a sticky
// overflow flag.
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   asynchronous reset, active-low
//   det       in   detection flag; every high cycle is one event
//   clr       in   synchronous clear of counters, flag, FIFO and timestamp
//   ev_ts     out  timestamp of the FIFO head entry (0 when empty)
//   ev_valid  out  FIFO non-empty
//   ev_ready  in   consumer accepts head entry when ev_valid is high
//   det_cnt   out  saturating count of detections
//   drop_cnt  out  saturating count of detections lost to a full FIFO
//   ovf       out  sticky flag, set on the first drop
// ---------------------------------------------------------------------------
module detect_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det,
    input  logic             clr,
    output logic [TS_W-1:0]  ev_ts,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [CNT_W-1:0] det_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             ovf
);

    localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [TS_W-1:0]  ts_q,       ts_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W:0]   count_q,    count_d;
    logic [CNT_W-1:0] det_cnt_q,  det_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             ovf_q,      ovf_d;
    logic [TS_W-1:0]  mem_q [DEPTH];

    logic empty, full, pop, push, drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign pop   = !empty && ev_ready;
    // A full FIFO can still accept a detection when the head leaves in the
    // same cycle; only a full FIFO with no pop loses the event.
    assign push  = det && (!full || pop);
    assign drop  = det && full && !pop;

    always_comb begin
        ts_d       = ts_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        det_cnt_d  = det_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;

        if (clr) begin
            ts_d       = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            det_cnt_d  = '0;
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            ts_d = ts_q + 1'b1;
            // Pointers are exactly log2(DEPTH) bits, so they wrap naturally.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (det) det_cnt_d = sat_inc(det_cnt_q);
            if (drop) begin
                drop_cnt_d = sat_inc(drop_cnt_q);
                ovf_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            det_cnt_q  <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            det_cnt_q  <= det_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage is not reset; the occupancy count decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[wr_ptr_q] <= ts_q;
    end

    // Head is read from registered storage and pointer only. Masking with
    // ev_valid keeps ev_ts at zero while empty, including during reset.
    assign ev_valid = !empty;
    assign ev_ts    = ev_valid ? mem_q[rd_ptr_q] : '0;
    assign det_cnt  = det_cnt_q;
    assign drop_cnt = drop_cnt_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_detect_event_logger.sv
module tb_detect_event_logger;

    localparam int DEPTH = 4;
    localparam int MAXC  = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        det = 1'b0;
    logic        clr = 1'b0;
    logic        ev_ready = 1'b0;
    logic [15:0] ev_ts;
    logic        ev_valid;
    logic [7:0]  det_cnt, drop_cnt;
    logic        ovf;
    logic [3:0]  ev_ts4;
    logic        ev_valid4;
    logic [7:0]  det_cnt4, drop_cnt4;
    logic        ovf4;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queue of timestamps plus plain integer counters.
    logic [15:0] mq[$];
    int          m_ts, m_det, m_drop;
    bit          m_ovf;

    always #5 clk = ~clk;

    detect_event_logger #(.TS_W(16), .DEPTH(DEPTH), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .det(det), .clr(clr),
        .ev_ts(ev_ts), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .det_cnt(det_cnt), .drop_cnt(drop_cnt), .ovf(ovf)
    );

    detect_event_logger #(.TS_W(4), .DEPTH(DEPTH), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .det(det), .clr(clr),
        .ev_ts(ev_ts4), .ev_valid(ev_valid4), .ev_ready(ev_ready),
        .det_cnt(det_cnt4), .drop_cnt(drop_cnt4), .ovf(ovf4)
    );

    task automatic model_reset();
        mq.delete();
        m_ts = 0; m_det = 0; m_drop = 0; m_ovf = 1'b0;
    endtask

    task automatic model_step(input bit d, input bit r, input bit c);
        bit popm, fullm;
        if (c) begin
            model_reset();
        end else begin
            popm  = (mq.size() > 0) && r;
            fullm = (mq.size() == DEPTH);
            if (d && m_det < MAXC) m_det++;
            if (popm) void'(mq.pop_front());
            if (d) begin
                if (!fullm || popm) mq.push_back(16'(m_ts));
                else begin
                    if (m_drop < MAXC) m_drop++;
                    m_ovf = 1'b1;
                end
            end
            m_ts = (m_ts + 1) % 65536;
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic tick(input bit d, input bit r, input bit c);
        det = d; ev_ready = r; clr = c;
        model_step(d, r, c);
        @(posedge clk); #1;
        det = 1'b0; ev_ready = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        det = 0; ev_ready = 0; clr = 0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        det = 0; ev_ready = 0; clr = 0;
        rst = 1'b0; #1;
        n_checks++; if (ev_valid !== 1'b0) $display("FAIL rst_valid got=%0d exp=0", ev_valid); else n_pass++;
        n_checks++; if (ev_ts !== 16'd0) $display("FAIL rst_ev_ts got=%0d exp=0", ev_ts); else n_pass++;
        n_checks++; if (det_cnt !== 8'd0) $display("FAIL rst_det_cnt got=%0d exp=0", det_cnt); else n_pass++;
        n_checks++; if (drop_cnt !== 8'd0) $display("FAIL rst_drop_cnt got=%0d exp=0", drop_cnt); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL rst_ovf got=%0d exp=0", ovf); else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        // First edge after release must capture ts=0.
        tick(1, 0, 0);
        n_checks++; if (ev_valid !== 1'b1) $display("FAIL first_ts_valid got=%0d exp=1", ev_valid); else n_pass++;
        n_checks++; if (ev_ts !== 16'd0) $display("FAIL first_ts got=%0d exp=0", ev_ts); else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        repeat (5) tick(0, 1, 0);
        tick(1, 1, 0);
        n_checks++; if (ev_valid !== 1'b1 || ev_ts !== 16'd5) $display("FAIL basic_ts5 got valid=%0d ts=%0d exp valid=1 ts=5", ev_valid, ev_ts); else n_pass++;
        tick(0, 1, 0);
        n_checks++; if (ev_valid !== 1'b0) $display("FAIL basic_pop5 got=%0d exp=0", ev_valid); else n_pass++;
        tick(1, 1, 0);
        n_checks++; if (ev_valid !== 1'b1 || ev_ts !== 16'd7) $display("FAIL basic_ts7 got valid=%0d ts=%0d exp valid=1 ts=7", ev_valid, ev_ts); else n_pass++;
        tick(0, 1, 0);
        n_checks++; if (ev_valid !== 1'b0) $display("FAIL basic_pop7 got=%0d exp=0", ev_valid); else n_pass++;
        n_checks++; if (det_cnt !== 8'd2) $display("FAIL basic_det_cnt got=%0d exp=2", det_cnt); else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        repeat (6) tick(1, 0, 0);
        n_checks++; if (drop_cnt !== 8'd2) $display("FAIL ovf_drop_cnt got=%0d exp=2", drop_cnt); else n_pass++;
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_flag got=%0d exp=1", ovf); else n_pass++;
        n_checks++; if (det_cnt !== 8'd6) $display("FAIL ovf_det_cnt got=%0d exp=6", det_cnt); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ev_valid !== 1'b1 || ev_ts !== 16'(i))
                $display("FAIL ovf_drain%0d got valid=%0d ts=%0d exp valid=1 ts=%0d", i, ev_valid, ev_ts, i);
            else n_pass++;
            tick(0, 1, 0);
        end
        n_checks++; if (ev_valid !== 1'b0) $display("FAIL ovf_drained got=%0d exp=0", ev_valid); else n_pass++;
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_sticky got=%0d exp=1", ovf); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        repeat (4) tick(1, 0, 0);
        tick(1, 1, 0);
        n_checks++; if (drop_cnt !== 8'd0 || ovf !== 1'b0) $display("FAIL fpp_nodrop got drop=%0d ovf=%0d exp 0 0", drop_cnt, ovf); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (ev_valid !== 1'b1 || ev_ts !== 16'(i))
                $display("FAIL fpp_drain%0d got valid=%0d ts=%0d exp valid=1 ts=%0d", i, ev_valid, ev_ts, i);
            else n_pass++;
            tick(0, 1, 0);
        end
        n_checks++; if (ev_valid !== 1'b0) $display("FAIL fpp_empty got=%0d exp=0", ev_valid); else n_pass++;
    endtask

    task automatic test_clr();
        do_reset();
        repeat (3) tick(1, 0, 0);
        repeat (3) tick(1, 0, 0);
        tick(1, 1, 1);
        n_checks++; if (det_cnt !== 8'd0 || drop_cnt !== 8'd0 || ovf !== 1'b0) $display("FAIL clr_counters got det=%0d drop=%0d ovf=%0d exp 0 0 0", det_cnt, drop_cnt, ovf); else n_pass++;
        n_checks++; if (ev_valid !== 1'b0 || ev_ts !== 16'd0) $display("FAIL clr_fifo got valid=%0d ts=%0d exp 0 0", ev_valid, ev_ts); else n_pass++;
        tick(1, 0, 0);
        n_checks++; if (ev_ts !== 16'd0 || det_cnt !== 8'd1) $display("FAIL clr_ts_restart got ts=%0d det=%0d exp 0 1", ev_ts, det_cnt); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (3) tick(1, 0, 0);
        n_checks++; if (ev_valid !== 1'b1 || det_cnt !== 8'd3) $display("FAIL arst_pre got valid=%0d det=%0d exp 1 3", ev_valid, det_cnt); else n_pass++;
        #3 rst = 1'b0;
        #1;
        n_checks++; if (ev_valid !== 1'b0 || ev_ts !== 16'd0) $display("FAIL arst_fifo got valid=%0d ts=%0d exp 0 0", ev_valid, ev_ts); else n_pass++;
        n_checks++; if (det_cnt !== 8'd0 || drop_cnt !== 8'd0 || ovf !== 1'b0) $display("FAIL arst_counters got det=%0d drop=%0d ovf=%0d exp 0 0 0", det_cnt, drop_cnt, ovf); else n_pass++;
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
    endtask

    task automatic test_wrap_sat();
        do_reset();
        repeat (17) tick(0, 0, 0);
        tick(1, 0, 0);
        n_checks++; if (ev_valid4 !== 1'b1 || ev_ts4 !== 4'd1) $display("FAIL wrap_ts4 got valid=%0d ts=%0d exp 1 1", ev_valid4, ev_ts4); else n_pass++;
        n_checks++; if (ev_ts !== 16'd17) $display("FAIL wrap_ts16 got=%0d exp=17", ev_ts); else n_pass++;
        repeat (300) tick(1, 1, 0);
        n_checks++; if (det_cnt !== 8'd255) $display("FAIL sat_det_cnt got=%0d exp=255", det_cnt); else n_pass++;
        n_checks++; if (det_cnt4 !== 8'd255) $display("FAIL sat_det_cnt4 got=%0d exp=255", det_cnt4); else n_pass++;
        n_checks++; if (drop_cnt !== 8'(m_drop) || drop_cnt4 !== 8'(m_drop)) $display("FAIL sat_drop got=%0d/%0d exp=%0d", drop_cnt, drop_cnt4, m_drop); else n_pass++;
    endtask

    task automatic test_random();
        bit d, r, c;
        logic [15:0] exp_ts;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            d = ($urandom_range(0, 3) != 0);
            r = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 79) == 0);
            tick(d, r, c);
            exp_ts = (mq.size() > 0) ? mq[0] : 16'd0;
            n_checks++; if (ev_valid !== (mq.size() > 0)) $display("FAIL rnd_valid cyc=%0d got=%0d exp=%0d", i, ev_valid, mq.size() > 0); else n_pass++;
            n_checks++; if (ev_ts !== exp_ts) $display("FAIL rnd_ts cyc=%0d got=%0d exp=%0d", i, ev_ts, exp_ts); else n_pass++;
            n_checks++; if (ev_ts4 !== exp_ts[3:0] || ovf4 !== m_ovf) $display("FAIL rnd_dut4 cyc=%0d got ts=%0d ovf=%0d exp ts=%0d ovf=%0d", i, ev_ts4, ovf4, exp_ts[3:0], m_ovf); else n_pass++;
            n_checks++; if (det_cnt !== 8'(m_det)) $display("FAIL rnd_det_cnt cyc=%0d got=%0d exp=%0d", i, det_cnt, m_det); else n_pass++;
            n_checks++; if (drop_cnt !== 8'(m_drop)) $display("FAIL rnd_drop_cnt cyc=%0d got=%0d exp=%0d", i, drop_cnt, m_drop); else n_pass++;
            n_checks++; if (ovf !== m_ovf) $display("FAIL rnd_ovf cyc=%0d got=%0d exp=%0d", i, ovf, m_ovf); else n_pass++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_clr();
        test_async_reset();
        test_wrap_sat();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/detect_event_logger.md
DETECT_EVENT_LOGGER -- requirements
Module: detect_event_logger

Interface
REQ-001 Parameter TS_W, default 16: timestamp width in bits.
REQ-002 Parameter DEPTH, default 4: event FIFO entries, power of two, minimum 2.
REQ-003 Parameter CNT_W, default 8: width of the detection and drop counters.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 det  input  1  detection flag from the upstream sequence detector; each cycle high is one event.
REQ-007 clr  input  1  synchronous clear of counters, sticky flag, FIFO and timestamp.
REQ-008 ev_ts  output  TS_W  timestamp of the FIFO head entry.
REQ-009 ev_valid  output  1  FIFO non-empty; ev_ts is valid.
REQ-010 ev_ready  input  1  consumer accepts the head entry when ev_valid and ev_ready are both high.
REQ-011 det_cnt  output  CNT_W  total detections seen, saturating.
REQ-012 drop_cnt  output  CNT_W  detections lost to a full FIFO, saturating.
REQ-013 ovf  output  1  sticky flag, set on the first drop.

Function
REQ-014 A free-running counter ts shall increment by 1 every cycle and wrap from 2^TS_W-1 to 0.
REQ-015 On a cycle with det=1, the current ts value (before increment) shall be the event timestamp.
REQ-016 A push shall occur when det=1 and the FIFO is not full, or when det=1, the FIFO is full and a pop occurs in the same cycle.
REQ-017 A pop shall occur when ev_valid=1 and ev_ready=1; the next entry shall appear on ev_ts the following cycle.
REQ-018 Write-to-read latency: an event pushed in cycle N shall make ev_valid=1 in cycle N+1 if the FIFO was empty.
REQ-019 ev_ts shall be driven from registered FIFO storage and read pointer only, with no combinational path from det.
REQ-020 When the FIFO is empty, a simultaneous push and pop shall not occur, since ev_valid=0 blocks the pop.
REQ-021 Occupancy shall track 0..DEPTH, with distinct full (occupancy=DEPTH) and empty (occupancy=0) conditions; read and write pointers shall wrap modulo DEPTH.
REQ-022 det_cnt shall increment on every det=1 cycle and hold at 2^CNT_W-1.
REQ-023 A drop shall occur when det=1, the FIFO is full and no pop occurs in that cycle.
REQ-024 On a drop, drop_cnt shall increment, saturating at 2^CNT_W-1, and ovf shall set to 1.
REQ-025 ovf shall remain 1 until clr or reset.
REQ-026 A dropped event shall not alter FIFO contents or pointers.
REQ-027 clr=1 shall clear det_cnt, drop_cnt, ovf, ts and FIFO occupancy at the next edge, taking priority over det and pop in that cycle.
REQ-028 Consecutive det=1 cycles shall each be logged as separate events; no edge detection is performed on det.
REQ-029 ev_ready while ev_valid=0 shall have no effect.

Reset
REQ-030 rst=0 shall immediately force the following, independent of clk: ts=0, det_cnt=0, drop_cnt=0, ovf=0, ev_valid=0, FIFO pointers=0 and ev_ts=0.
REQ-031 FIFO storage contents need not be reset.
REQ-032 Assertion of rst mid-operation shall discard all queued events.
REQ-033 The first ts increment shall occur on the first rising clk edge after rst deasserts.

Verification
REQ-034 Scenario: reset release, det high at ts=5 and ts=7, ev_ready=1 -> ev_ts=5 then 7, each ev_valid for one cycle, det_cnt=2.
REQ-035 Scenario: ev_ready=0, six det pulses with DEPTH=4 -> four entries held; drop_cnt=2, ovf=1, det_cnt=6; draining yields the first four timestamps in order.
REQ-036 Scenario: FIFO full, det=1 and ev_ready=1 in the same cycle -> no drop, occupancy stays 4, new timestamp enqueued last.
REQ-037 Scenario: TS_W=4, det at cycle 17 after reset -> ev_ts=1 (wrap); det_cnt=2^CNT_W-1 after 300 pulses with CNT_W=8 (saturation).
REQ-038 Scenario: clr=1 coincident with det=1 -> all counters 0, ev_valid=0, event not logged.
REQ-039 Scenario: rst asserted asynchronously between clock edges while FIFO holds 3 entries -> ev_valid=0 and counters 0 before the next clk edge.
